// File: rtl/disp_scan_rx.sv
// Loop-back monitor for a multiplexed 7-segment display bus.
// Decodes each scanned digit back to a nibble and reassembles the 16-bit word plus decimal points.
module disp_scan_rx #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  AN,
    input  logic [6:0]  seg,
    input  logic        seg_P,
    output logic [15:0] dat,
    output logic [3:0]  dp,
    output logic        frame_vld,
    output logic        seg_err,
    output logic        stall
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Returns {illegal, nibble}; anything outside the hex font (blank included) is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    function automatic logic an_legal(input logic [3:0] an);
        logic r;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] r;
        case (an)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [3:0]    an_meta_q, an_sync_q;
    logic [6:0]    seg_meta_q, seg_sync_q;
    logic          segp_meta_q, segp_sync_q;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [3:0]    an_ref_q, an_ref_d;
    logic [6:0]    seg_ref_q, seg_ref_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    sdp_q, sdp_d;
    logic [3:0]    seen_q, seen_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   dat_q, dat_d;
    logic [3:0]    dp_q, dp_d;
    logic          frame_vld_q, frame_vld_d;
    logic          seg_err_q, seg_err_d;
    logic          stall_q, stall_d;

    logic          sample_s;
    logic          tmo_hit_s;
    logic [4:0]    dec_s;
    logic [1:0]    k_s;

    // Two-flop synchronizer; idle levels are all-high since every line is active low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q   <= 4'hF;
            an_sync_q   <= 4'hF;
            seg_meta_q  <= 7'h7F;
            seg_sync_q  <= 7'h7F;
            segp_meta_q <= 1'b1;
            segp_sync_q <= 1'b1;
        end else begin
            an_meta_q   <= AN;
            an_sync_q   <= an_meta_q;
            seg_meta_q  <= seg;
            seg_sync_q  <= seg_meta_q;
            segp_meta_q <= seg_P;
            segp_sync_q <= segp_meta_q;
        end
    end

    // Digit qualification FSM: one sample per anode activation once AN/seg have been quiet long enough.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        an_ref_d  = an_ref_q;
        seg_ref_d = seg_ref_q;
        sample_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (an_legal(an_sync_q)) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = SW'(1);
                    an_ref_d  = an_sync_q;
                    seg_ref_d = seg_sync_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!an_legal(an_sync_q)) begin
                    state_d = ST_IDLE;
                end else if ((an_sync_q != an_ref_q) || (seg_sync_q != seg_ref_q)) begin
                    cnt_d     = SW'(1);
                    an_ref_d  = an_sync_q;
                    seg_ref_d = seg_sync_q;
                end else if (cnt_q >= SW'(SETTLE - 1)) begin
                    sample_s = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            ST_HOLD: begin
                if (an_sync_q != an_ref_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame assembly, delivery and stall watchdog.
    always_comb begin
        dec_s       = seg_decode(seg_sync_q);
        k_s         = an_index(an_sync_q);
        shadow_d    = shadow_q;
        sdp_d       = sdp_q;
        seen_d      = seen_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        dat_d       = dat_q;
        dp_d        = dp_q;
        frame_vld_d = 1'b0;
        seg_err_d   = seg_err_q;
        stall_d     = stall_q;
        tmo_hit_s   = 1'b0;

        if (sample_s) begin
            tmo_d   = {TW{1'b0}};
            stall_d = 1'b0;
        end else if (tmo_q != TW'(TIMEOUT)) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_d == TW'(TIMEOUT)) begin
                tmo_hit_s = 1'b1;
                stall_d   = 1'b1;
            end else begin
                tmo_hit_s = 1'b0;
            end
        end else begin
            tmo_d = tmo_q;
        end

        if (seen_q == 4'hF) begin
            dat_d       = shadow_q;
            dp_d        = sdp_q;
            seg_err_d   = err_q;
            frame_vld_d = 1'b1;
            seen_d      = 4'h0;
            err_d       = 1'b0;
        end else if (sample_s) begin
            // A digit seen twice before the frame filled up starts a fresh frame.
            if (seen_q[k_s]) begin
                seen_d = 4'b0001 << k_s;
                err_d  = dec_s[4];
            end else begin
                seen_d = seen_q | (4'b0001 << k_s);
                err_d  = err_q | dec_s[4];
            end
            shadow_d[{k_s, 2'b00} +: 4] = dec_s[3:0];
            sdp_d[k_s]                  = ~segp_sync_q;
        end else if (tmo_hit_s) begin
            seen_d = 4'h0;
            err_d  = 1'b0;
        end else begin
            seen_d = seen_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {SW{1'b0}};
            an_ref_q    <= 4'hF;
            seg_ref_q   <= 7'h7F;
            shadow_q    <= 16'h0000;
            sdp_q       <= 4'h0;
            seen_q      <= 4'h0;
            err_q       <= 1'b0;
            tmo_q       <= {TW{1'b0}};
            dat_q       <= 16'h0000;
            dp_q        <= 4'h0;
            frame_vld_q <= 1'b0;
            seg_err_q   <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            an_ref_q    <= an_ref_d;
            seg_ref_q   <= seg_ref_d;
            shadow_q    <= shadow_d;
            sdp_q       <= sdp_d;
            seen_q      <= seen_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            dat_q       <= dat_d;
            dp_q        <= dp_d;
            frame_vld_q <= frame_vld_d;
            seg_err_q   <= seg_err_d;
            stall_q     <= stall_d;
        end
    end

    assign dat       = dat_q;
    assign dp        = dp_q;
    assign frame_vld = frame_vld_q;
    assign seg_err   = seg_err_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_disp_scan_rx.sv
// Directed bench for disp_scan_rx: a frame-level model predicts every delivered frame,
// and a per-cycle compare process holds the DUT outputs against it.
module tb_disp_scan_rx;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 300;
    localparam int DW      = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  AN;
    logic [6:0]  seg;
    logic        seg_P;
    logic [15:0] dat;
    logic [3:0]  dp;
    logic        frame_vld;
    logic        seg_err;
    logic        stall;

    disp_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AN        (AN),
        .seg       (seg),
        .seg_P     (seg_P),
        .dat       (dat),
        .dp        (dp),
        .frame_vld (frame_vld),
        .seg_err   (seg_err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dat;
        logic [3:0]  dp;
        logic        err;
    } frame_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         frames_got = 0;
    int         fv_cyc = 0;
    int         last_drive = 0;
    frame_t     exp_q[$];
    frame_t     cur;
    logic [6:0] seg_tbl [16];
    logic [3:0] m_nib [4];
    logic [3:0] m_dp;
    logic [3:0] m_seen;
    logic       m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Frame-level model: a frame is the first time all four digits have been captured.
    task automatic m_sample(input int k, input logic [6:0] code, input logic lit);
        logic [3:0] nib;
        logic       bad;
        nib = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg_tbl[i] == code) begin
                nib = i[3:0];
                bad = 1'b0;
            end
        end
        if (m_seen[k]) begin
            m_seen = 4'h0;
            m_err  = 1'b0;
        end
        m_nib[k]  = nib;
        m_dp[k]   = lit;
        m_seen[k] = 1'b1;
        m_err     = m_err | bad;
        if (m_seen == 4'hF) begin
            exp_q.push_back('{dat: {m_nib[3], m_nib[2], m_nib[1], m_nib[0]}, dp: m_dp, err: m_err});
            m_seen = 4'h0;
            m_err  = 1'b0;
        end
    endtask

    task automatic drive_digit(input int k, input logic [6:0] code, input logic lit,
                               input int glitch, input int dwell);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << k;
        @(negedge clk);
        last_drive = cyc;
        AN    = ~one_hot;
        seg_P = ~lit;
        seg   = (glitch > 0) ? (code ^ 7'h15) : code;
        repeat (glitch) @(negedge clk);
        seg = code;
        m_sample(k, code, lit);
        repeat (dwell - glitch - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        AN    = 4'hF;
        seg   = 7'h7F;
        seg_P = 1'b1;
        repeat (n - 1) @(negedge clk);
        if (n >= TIMEOUT) begin
            m_seen = 4'h0;
            m_err  = 1'b0;
        end
    endtask

    // ord nibble i = digit index scanned in position i; blank[k] drives seg=7F on digit k.
    task automatic scan(input logic [15:0] w, input logic [3:0] dpv, input logic [15:0] ord,
                        input logic [3:0] blank, input int glitch);
        int         k;
        logic [6:0] code;
        idle(4);
        for (int i = 0; i < 4; i++) begin
            k    = int'(ord[4*i +: 4]);
            code = blank[k] ? 7'h7F : seg_tbl[w[4*k +: 4]];
            drive_digit(k, code, dpv[k], glitch, DW);
        end
    endtask

    // Per-cycle compare against the model's current delivered frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur = '0;
            chk("rst_dat", {16'h0, dat}, 32'h0);
            chk("rst_flags", {26'h0, dp, frame_vld, seg_err}, 32'h0);
        end else begin
            if (frame_vld) begin
                frames_got++;
                fv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame_vld with dat=0x%0h, expected none", dat);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            chk("dat", {16'h0, dat}, {16'h0, cur.dat});
            chk("dp", {28'h0, dp}, {28'h0, cur.dp});
            chk("seg_err", {31'h0, seg_err}, {31'h0, cur.err});
        end
    end

    initial begin
        int lat;
        int f0;
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_dp   = 4'h0;
        m_seen = 4'h0;
        m_err  = 1'b0;
        cur    = '0;
        rst_n  = 1'b0;
        AN     = 4'hF;
        seg    = 7'h7F;
        seg_P  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_dat", {16'h0, dat}, 32'h0);
        #2 rst_n = 1'b1;

        // 1: in-order scan, checked twice, with delivery latency
        scan(16'h12AF, 4'h0, 16'h3210, 4'h0, 0);
        lat = fv_cyc - last_drive;
        checks++;
        if (lat < SETTLE + 3 || lat > SETTLE + 4) begin
            errors++;
            $display("FAIL t1_latency: got %0d cycles, expected %0d..%0d", lat, SETTLE + 3, SETTLE + 4);
        end
        chk("t1_frames", frames_got, 1);
        chk("t1_dat", {16'h0, dat}, 32'h12AF);
        scan(16'h12AF, 4'h0, 16'h3210, 4'h0, 0);
        chk("t1_frames2", frames_got, 2);
        chk("t1_stall", {31'h0, stall}, 32'h0);

        // 2: shuffled order with a decimal point on digit 2
        scan(16'h12AF, 4'b0100, 16'h2013, 4'h0, 0);
        chk("t2_dp", {28'h0, dp}, 32'h4);
        chk("t2_dat", {16'h0, dat}, 32'h12AF);

        // 3: blank digit 1, then a clean frame
        scan(16'h12AF, 4'h0, 16'h3210, 4'b0010, 0);
        chk("t3_dat", {16'h0, dat}, 32'h120F);
        chk("t3_err", {31'h0, seg_err}, 32'h1);
        scan(16'h12AF, 4'h0, 16'h3210, 4'h0, 0);
        chk("t3_clean_err", {31'h0, seg_err}, 32'h0);

        // 4: short seg glitch per digit, then an anode pulse too short to sample
        scan(16'h5C3E, 4'h0, 16'h3210, 4'h0, SETTLE - 2);
        chk("t4_glitch_dat", {16'h0, dat}, 32'h5C3E);
        f0 = frames_got;
        idle(6);
        drive_digit(0, seg_tbl[7], 1'b0, 0, DW);
        drive_digit(1, seg_tbl[0], 1'b0, 0, DW);
        drive_digit(2, seg_tbl[13], 1'b0, 0, DW);
        idle(6);
        @(negedge clk);
        AN  = 4'b0111;
        seg = seg_tbl[9];
        repeat (SETTLE - 2) @(negedge clk);
        idle(30);
        chk("t4_pulse_frames", frames_got, f0);
        drive_digit(3, seg_tbl[9], 1'b0, 0, DW);
        chk("t4_frames", frames_got, f0 + 1);
        chk("t4_dat", {16'h0, dat}, 32'h9D07);

        // 5: repeated digits restart the frame
        f0 = frames_got;
        idle(4);
        drive_digit(0, seg_tbl[7], 1'b0, 0, DW);
        drive_digit(1, seg_tbl[7], 1'b0, 0, DW);
        drive_digit(0, seg_tbl[15], 1'b0, 0, DW);
        drive_digit(1, seg_tbl[10], 1'b0, 0, DW);
        drive_digit(2, seg_tbl[2], 1'b0, 0, DW);
        drive_digit(3, seg_tbl[1], 1'b0, 0, DW);
        chk("t5_frames", frames_got, f0 + 1);
        chk("t5_dat", {16'h0, dat}, 32'h12AF);

        // 6: stall discards a partial frame; resumed scan clears it
        f0 = frames_got;
        idle(4);
        drive_digit(0, seg_tbl[1], 1'b0, 0, DW);
        drive_digit(1, seg_tbl[2], 1'b0, 0, DW);
        idle(TIMEOUT + 10);
        chk("t6_stall", {31'h0, stall}, 32'h1);
        chk("t6_no_frame", frames_got, f0);
        drive_digit(2, seg_tbl[11], 1'b0, 0, DW);
        chk("t6_stall_clr", {31'h0, stall}, 32'h0);
        drive_digit(3, seg_tbl[8], 1'b0, 0, DW);
        drive_digit(0, seg_tbl[14], 1'b0, 0, DW);
        chk("t6_partial_frames", frames_got, f0);
        drive_digit(1, seg_tbl[6], 1'b0, 0, DW);
        chk("t6_frames", frames_got, f0 + 1);
        chk("t6_dat", {16'h0, dat}, 32'h8B6E);

        // 6b: reset mid-frame discards the partial scan
        f0 = frames_got;
        idle(4);
        drive_digit(0, seg_tbl[13], 1'b0, 0, DW);
        drive_digit(1, seg_tbl[12], 1'b1, 0, DW);
        @(negedge clk);
        #2 rst_n = 1'b0;
        m_seen = 4'h0;
        m_err  = 1'b0;
        @(negedge clk);
        chk("t6_rst_dat", {16'h0, dat}, 32'h0);
        chk("t6_rst_flags", {27'h0, dp, seg_err, stall}, 32'h0);
        #2 rst_n = 1'b1;
        drive_digit(2, seg_tbl[11], 1'b0, 0, DW);
        drive_digit(3, seg_tbl[10], 1'b0, 0, DW);
        idle(10);
        chk("t6_rst_no_frame", frames_got, f0);
        chk("pending_frames", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
